// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package     : mem_arbiter_pkg
// Description : Shared types and constants for the fetch/data memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package mem_arbiter_pkg;

   // Arbiter sequencing: IDLE -> REQ (memory handshake) -> RESP (one-cycle pulse)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Which requester currently owns the memory port
   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } arb_owner_t;

   // Transfer size encodings (log2 of the byte count)
   localparam logic [2:0] MSIZE1 = 3'd0;
   localparam logic [2:0] MSIZE2 = 3'd1;
   localparam logic [2:0] MSIZE4 = 3'd2;
   localparam logic [2:0] MSIZE8 = 3'd3;

   // Request fields captured at grant time and replayed to memory
   typedef struct packed {
      logic [63:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } mem_req_t;

   // Pick the 32-bit instruction word out of a 64-bit memory beat
   function automatic logic [31:0] word_select(input logic [63:0] dword, input logic hi);
      return hi ? dword[63:32] : dword[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_arb_timer
// Description : Counts request cycles without a memory response and flags
//               the last permitted cycle. TIMEOUT_CYCLES = 0 disables it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_arb_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYCLES - 1);

         logic [CW-1:0] r_count;

         // count waiting cycles; the count never passes c_last because the
         // arbiter drops enable once expired is seen
         always_ff @(posedge clk) begin
            if (!reset) begin
               r_count <= '0;
            end else if (clear) begin
               r_count <= '0;
            end else if (enable) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign expired = (r_count == c_last);
      end else begin : g_no_timeout
         logic w_unused;
         assign w_unused = &{1'b0, clk, reset, clear, enable};
         assign expired  = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Shares one memory port between the fetch stage and the memory
//               stage. Latches the winner, holds it on the memory bus until
//               accepted, then returns a one-cycle data_ok pulse to its owner.
//               Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise
//               data requests always beat fetch requests.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   // fetch stage
   input  logic        ireq_valid,
   input  logic [63:0] ireq_addr,
   output logic        iresp_data_ok,
   output logic [31:0] iresp_data,
   // memory stage
   input  logic        dreq_valid,
   input  logic [63:0] dreq_addr,
   input  logic        dreq_write,
   input  logic [2:0]  dreq_size,
   input  logic [7:0]  dreq_strobe,
   input  logic [63:0] dreq_data,
   output logic        dresp_data_ok,
   output logic [63:0] dresp_data,
   // memory bus
   output logic        mreq_valid,
   output logic [63:0] mreq_addr,
   output logic        mreq_write,
   output logic [2:0]  mreq_size,
   output logic [7:0]  mreq_strobe,
   output logic [63:0] mreq_data,
   input  logic        mresp_ready,
   input  logic [63:0] mresp_data,
   // status
   output logic        timeout_err
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   arb_owner_t  r_owner;
   arb_owner_t  w_owner_nxt;

   mem_req_t    r_req;
   mem_req_t    w_fetch_req;
   mem_req_t    w_data_req;

   logic [31:0] r_iresp;
   logic [63:0] r_dresp;
   logic        r_timeout;

   logic        w_grant;
   logic        w_pick_data;
   logic        w_complete;
   logic        w_abort;
   logic        w_tmr_clear;
   logic        w_tmr_enable;
   logic        w_tmr_expired;

   //---------------------------------------------------------------------------
   // Tie-break policy
   //---------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
   arb_owner_t r_last_owner;

   // remember who was granted last so a tie goes to the other requester
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_owner <= FETCH;
      end else if (w_grant) begin
         r_last_owner <= w_owner_nxt;
      end
   end

   assign w_pick_data = dreq_valid && (!ireq_valid || (r_last_owner == FETCH));
`else
   // the mem-stage instruction is older, so data always wins a tie
   assign w_pick_data = dreq_valid;
`endif

   //---------------------------------------------------------------------------
   // Candidate request images
   //---------------------------------------------------------------------------
   // fetches are always aligned 4-byte reads
   always_comb begin
      w_fetch_req      = '0;
      w_fetch_req.addr = ireq_addr;
      w_fetch_req.size = MSIZE4;
   end

   // data requests pass their fields through untouched
   always_comb begin
      w_data_req        = '0;
      w_data_req.addr   = dreq_addr;
      w_data_req.write  = dreq_write;
      w_data_req.size   = dreq_size;
      w_data_req.strobe = dreq_strobe;
      w_data_req.data   = dreq_data;
   end

   //---------------------------------------------------------------------------
   // Control FSM
   //---------------------------------------------------------------------------
   // state and owner register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_owner <= NONE;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   // next-state decode plus the handshake outputs that follow the state
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_grant       = 1'b0;
      w_complete    = 1'b0;
      w_abort       = 1'b0;
      mreq_valid    = 1'b0;
      iresp_data_ok = 1'b0;
      dresp_data_ok = 1'b0;
      case (r_state)
         IDLE: begin
            if (ireq_valid || dreq_valid) begin
               w_grant     = 1'b1;
               w_owner_nxt = w_pick_data ? DATA : FETCH;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            mreq_valid = 1'b1;
            if (mresp_ready) begin
               w_complete  = 1'b1;
               w_state_nxt = RESP;
            end else if (w_tmr_expired) begin
               w_abort     = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            iresp_data_ok = (r_owner == FETCH);
            dresp_data_ok = (r_owner == DATA);
            w_owner_nxt   = NONE;
            w_state_nxt   = IDLE;
         end
         default: begin
            w_owner_nxt = NONE;
            w_state_nxt = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Request / response datapath
   //---------------------------------------------------------------------------
   // capture the winner at grant, and the response (or zero on abort) when
   // leaving REQ; response registers then hold until the next RESP
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_req     <= '0;
         r_iresp   <= '0;
         r_dresp   <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_grant) begin
            r_req <= w_pick_data ? w_data_req : w_fetch_req;
         end
         if (w_complete) begin
            r_dresp <= mresp_data;
            r_iresp <= word_select(mresp_data, r_req.addr[2]);
         end else if (w_abort) begin
            r_dresp   <= '0;
            r_iresp   <= '0;
            r_timeout <= 1'b1;
         end
      end
   end

   assign mreq_addr   = r_req.addr;
   assign mreq_write  = r_req.write;
   assign mreq_size   = r_req.size;
   assign mreq_strobe = r_req.strobe;
   assign mreq_data   = r_req.data;
   assign iresp_data  = r_iresp;
   assign dresp_data  = r_dresp;
   assign timeout_err = r_timeout;

   //---------------------------------------------------------------------------
   // Response timeout
   //---------------------------------------------------------------------------
   assign w_tmr_clear  = (r_state != REQ);
   assign w_tmr_enable = (r_state == REQ) && !mresp_ready && !w_tmr_expired;

   mem_arb_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_tmr_clear),
      .enable  (w_tmr_enable),
      .expired (w_tmr_expired)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (timeout set to 8 cycles).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int TMO     = 8;
   localparam int MAXWAIT = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic        dreq_write;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        mreq_valid;
   logic [63:0] mreq_addr;
   logic        mreq_write;
   logic [2:0]  mreq_size;
   logic [7:0]  mreq_strobe;
   logic [63:0] mreq_data;
   logic        mresp_ready;
   logic [63:0] mresp_data;
   logic        timeout_err;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          mem_lat      = 0;
   int          mem_cnt      = 0;
   logic [63:0] mem_rdata    = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .reset         (reset),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .iresp_data_ok (iresp_data_ok),
      .iresp_data    (iresp_data),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_write    (dreq_write),
      .dreq_size     (dreq_size),
      .dreq_strobe   (dreq_strobe),
      .dreq_data     (dreq_data),
      .dresp_data_ok (dresp_data_ok),
      .dresp_data    (dresp_data),
      .mreq_valid    (mreq_valid),
      .mreq_addr     (mreq_addr),
      .mreq_write    (mreq_write),
      .mreq_size     (mreq_size),
      .mreq_strobe   (mreq_strobe),
      .mreq_data     (mreq_data),
      .mresp_ready   (mresp_ready),
      .mresp_data    (mresp_data),
      .timeout_err   (timeout_err)
   );

   // Advance one clock; memory model answers mem_lat cycles into a request.
   task automatic step();
      @(posedge clk);
      #1;
      if (mreq_valid === 1'b1) begin
         mresp_ready = (mem_cnt == mem_lat);
         mresp_data  = mresp_ready ? mem_rdata : {$urandom, $urandom};
         mem_cnt++;
      end else begin
         mresp_ready = 1'b0;
         mresp_data  = {$urandom, $urandom};
         mem_cnt     = 0;
      end
   endtask

   // Step until any data_ok (bounded); n = cycles stepped.
   task automatic wait_ok(output int n, output logic gi, output logic gd);
      n  = 0;
      gi = 1'b0;
      gd = 1'b0;
      while (n < MAXWAIT && !gi && !gd) begin
         step();
         n++;
         gi = iresp_data_ok;
         gd = dresp_data_ok;
      end
   endtask

   task automatic clear_inputs();
      ireq_valid = 0; ireq_addr = 0;
      dreq_valid = 0; dreq_addr = 0; dreq_write = 0;
      dreq_size = 0; dreq_strobe = 0; dreq_data = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      mresp_ready = 0; mresp_data = 0;
      ireq_valid = 1; ireq_addr = 64'h1000;
      dreq_valid = 1; dreq_addr = 64'h2000; dreq_write = 1; dreq_size = 3;
      dreq_strobe = 8'hFF; dreq_data = 64'h55;
      step(); step(); step();
      tests_run++;
      if (mreq_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_mreq_valid: got %b expected 0", mreq_valid);
      end
      tests_run++;
      if ({iresp_data_ok, dresp_data_ok} !== 2'b00) begin
         tests_failed++; $display("FAIL reset_data_ok: got %b expected 00", {iresp_data_ok, dresp_data_ok});
      end
      tests_run++;
      if (timeout_err !== 1'b0) begin
         tests_failed++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
      end
      tests_run++;
      if ({mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_data} !== '0) begin
         tests_failed++; $display("FAIL reset_mreq_fields: got %h/%b/%0d/%h/%h expected all 0",
                                  mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_data);
      end
      tests_run++;
      if ({iresp_data, dresp_data} !== '0) begin
         tests_failed++; $display("FAIL reset_resp_data: got %h/%h expected 0", iresp_data, dresp_data);
      end
      reset = 1'b1;
      clear_inputs();
      step();
      tests_run++;
      if (mreq_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_release_idle: got mreq_valid %b expected 0", mreq_valid);
      end
   endtask

   task automatic test_fetch();
      int n; logic gi, gd;
      do_reset();
      mem_lat = 2; mem_rdata = 64'hDEADBEEF_12345678;
      ireq_valid = 1; ireq_addr = 64'h8000_0004;
      step();
      tests_run++;
      if ({mreq_valid, mreq_write, mreq_size, mreq_addr} !== {1'b1, 1'b0, 3'd2, 64'h8000_0004}) begin
         tests_failed++; $display("FAIL fetch_mreq: got v%b w%b s%0d a%h expected v1 w0 s2 a8000_0004",
                                  mreq_valid, mreq_write, mreq_size, mreq_addr);
      end
      wait_ok(n, gi, gd);
      tests_run++;
      if ({gi, gd} !== 2'b10 || n != 3) begin
         tests_failed++; $display("FAIL fetch_data_ok: got ok=%b%b after %0d cycles expected 10 after 3", gi, gd, n);
      end
      tests_run++;
      if (iresp_data !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL fetch_iresp_data: got %h expected deadbeef", iresp_data);
      end
      ireq_valid = 0;
      step();
      tests_run++;
      if ({iresp_data_ok, mreq_valid} !== 2'b00 || iresp_data !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL fetch_pulse: got ok=%b v=%b data=%h expected 0 0 deadbeef",
                                  iresp_data_ok, mreq_valid, iresp_data);
      end
   endtask

   task automatic test_store();
      int n; logic got;
      logic [139:0] exp_f;
      do_reset();
      mem_lat = 3; mem_rdata = {$urandom, $urandom};
      dreq_valid = 1; dreq_write = 1; dreq_addr = 64'h8000_0010; dreq_size = 3;
      dreq_strobe = 8'hFF; dreq_data = 64'h1122334455667788;
      exp_f = {64'h8000_0010, 1'b1, 3'd3, 8'hFF, 64'h1122334455667788};
      step();
      n = 0; got = 0;
      while (!got && n < MAXWAIT) begin
         tests_run++;
         if (mreq_valid !== 1'b1 || {mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_data} !== exp_f) begin
            tests_failed++; $display("FAIL store_fields: got v%b %h expected v1 %h", mreq_valid,
                                     {mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_data}, exp_f);
         end
         step();
         n++;
         got = dresp_data_ok;
      end
      tests_run++;
      if (!got || n != 4 || iresp_data_ok !== 1'b0) begin
         tests_failed++; $display("FAIL store_data_ok: got ok=%b after %0d cycles expected 1 after 4", got, n);
      end
      tests_run++;
      if (dresp_data !== mem_rdata) begin
         tests_failed++; $display("FAIL store_dresp_data: got %h expected %h", dresp_data, mem_rdata);
      end
      clear_inputs();
      step();
   endtask

   // Two ties in a row: data served, data re-requests while fetch still waits.
   task automatic test_back_to_back();
      int n; logic gi, gd;
      logic [2:0]  exp_d;   // 1 = data expected for service k
      logic [63:0] a_i, a_d0, a_d1, exp_a;
      logic        d_round;
`ifdef MEM_ARB_RR_EN
      exp_d = 3'b101;
`else
      exp_d = 3'b011;
`endif
      do_reset();
      mem_lat = 1;
      a_i = 64'h0000_1000; a_d0 = 64'h0000_2000; a_d1 = 64'h0000_3000;
      ireq_valid = 1; ireq_addr = a_i;
      dreq_valid = 1; dreq_addr = a_d0;
      d_round = 0;
      for (int k = 0; k < 3; k++) begin
         mem_rdata = {$urandom, $urandom};
         step();
         exp_a = exp_d[k] ? (d_round ? a_d1 : a_d0) : a_i;
         tests_run++;
         if (mreq_valid !== 1'b1 || mreq_addr !== exp_a) begin
            tests_failed++; $display("FAIL b2b_grant%0d: got v%b a%h expected v1 a%h", k, mreq_valid, mreq_addr, exp_a);
         end
         wait_ok(n, gi, gd);
         tests_run++;
         if ({gi, gd} !== {!exp_d[k], exp_d[k]} || n != 2) begin
            tests_failed++; $display("FAIL b2b_owner%0d: got ok=%b%b after %0d expected %b%b after 2",
                                     k, gi, gd, n, !exp_d[k], exp_d[k]);
         end
         if (gd) dreq_valid = 0;
         if (gi) ireq_valid = 0;
         step();
         if (k == 0) begin
            dreq_valid = 1; dreq_addr = a_d1; d_round = 1;
         end
      end
      step();
      tests_run++;
      if (mreq_valid !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_drain: got mreq_valid %b expected 0", mreq_valid);
      end
   endtask

   task automatic test_field_change();
      int n; logic got;
      do_reset();
      mem_lat = 4;
      dreq_valid = 1; dreq_addr = 64'hA5A5_0000_0000_0040; dreq_size = 2; dreq_data = 64'h77;
      step();
      dreq_addr = 64'h5A5A_FFFF_FFFF_FFB8; dreq_data = 64'h99;
      n = 0; got = 0;
      while (!got && n < MAXWAIT) begin
         if (mreq_valid === 1'b1) begin
            tests_run++;
            if (mreq_addr !== 64'hA5A5_0000_0000_0040 || mreq_data !== 64'h77) begin
               tests_failed++; $display("FAIL field_change_hold: got a%h d%h expected aa5a5000000000040 d77",
                                        mreq_addr, mreq_data);
            end
         end
         step();
         n++;
         got = dresp_data_ok;
      end
      tests_run++;
      if (!got) begin
         tests_failed++; $display("FAIL field_change_done: got no data_ok expected one");
      end
      clear_inputs();
      step();
   endtask

   // Random traffic checked against a transaction-level arbitration model.
   task automatic test_random();
      int n; logic gi, gd;
      logic        pend_i, pend_d, pick_d, last_data;
      logic [63:0] m_ia, m_da, m_dd, rd;
      logic        m_dw;
      logic [2:0]  m_ds;
      logic [7:0]  m_dst;
      logic [139:0] exp_f;
      do_reset();
      pend_i = 0; pend_d = 0; last_data = 0;
      m_ia = 0; m_da = 0; m_dd = 0; m_dw = 0; m_ds = 0; m_dst = 0;
      for (int r = 0; r < 60; r++) begin
         if (!pend_i && ($urandom_range(0, 3) != 0)) begin
            pend_i = 1; m_ia = {$urandom, $urandom}; m_ia[1:0] = 2'b00;
            ireq_valid = 1; ireq_addr = m_ia;
         end
         if (!pend_d && ($urandom_range(0, 3) != 0)) begin
            pend_d = 1; m_da = {$urandom, $urandom}; m_dd = {$urandom, $urandom};
            m_dw = 1'($urandom_range(0, 1)); m_ds = 3'($urandom_range(0, 3)); m_dst = 8'($urandom);
            dreq_valid = 1; dreq_addr = m_da; dreq_data = m_dd;
            dreq_write = m_dw; dreq_size = m_ds; dreq_strobe = m_dst;
         end
         mem_lat = $urandom_range(0, 6);
         rd = {$urandom, $urandom};
         mem_rdata = rd;
         if (!pend_i && !pend_d) begin
            step();
            tests_run++;
            if (mreq_valid !== 1'b0) begin
               tests_failed++; $display("FAIL rand_idle r%0d: got mreq_valid %b expected 0", r, mreq_valid);
            end
            continue;
         end
`ifdef MEM_ARB_RR_EN
         pick_d = pend_d && (!pend_i || !last_data);
`else
         pick_d = pend_d;
`endif
         last_data = pick_d;
         exp_f = pick_d ? {m_da, m_dw, m_ds, m_dst, m_dd} : {m_ia, 1'b0, 3'd2, 8'h00, 64'h0};
         step();
         tests_run++;
         if (mreq_valid !== 1'b1 || {mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_data} !== exp_f) begin
            tests_failed++; $display("FAIL rand_mreq r%0d: got v%b %h expected v1 %h", r, mreq_valid,
                                     {mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_data}, exp_f);
         end
         wait_ok(n, gi, gd);
         tests_run++;
         if ({gi, gd} !== {!pick_d, pick_d} || n != mem_lat + 1) begin
            tests_failed++; $display("FAIL rand_ok r%0d: got ok=%b%b after %0d expected %b%b after %0d",
                                     r, gi, gd, n, !pick_d, pick_d, mem_lat + 1);
         end
         tests_run++;
         if (pick_d ? (dresp_data !== rd) : (iresp_data !== (m_ia[2] ? rd[63:32] : rd[31:0]))) begin
            tests_failed++; $display("FAIL rand_data r%0d: got i%h d%h expected from %h (data owner %b)",
                                     r, iresp_data, dresp_data, rd, pick_d);
         end
         if (pick_d) begin dreq_valid = 0; pend_d = 0; end
         else        begin ireq_valid = 0; pend_i = 0; end
         step();
      end
      clear_inputs();
      step();
   endtask

   task automatic test_timeout();
      int n; logic gi, gd;
      logic [63:0] rd;
      do_reset();
      mem_lat = 1; rd = 64'hCAFE_F00D_0000_0001; mem_rdata = rd;
      dreq_valid = 1; dreq_addr = 64'h100;
      step();
      wait_ok(n, gi, gd);
      dreq_valid = 0;
      step();
      tests_run++;
      if (timeout_err !== 1'b0 || dresp_data !== rd) begin
         tests_failed++; $display("FAIL timeout_pre: got err=%b d=%h expected 0 %h", timeout_err, dresp_data, rd);
      end
      mem_lat = 1000;
      dreq_valid = 1; dreq_addr = 64'h200;
      step();
      wait_ok(n, gi, gd);
      // request at t, mreq_valid t+1..t+8, data_ok at t+9 (tenth cycle)
      tests_run++;
      if ({gi, gd} !== 2'b01 || n != TMO) begin
         tests_failed++; $display("FAIL timeout_latency: got ok=%b%b after %0d expected 01 after %0d", gi, gd, n, TMO);
      end
      tests_run++;
      if (dresp_data !== 64'h0 || timeout_err !== 1'b1) begin
         tests_failed++; $display("FAIL timeout_result: got d=%h err=%b expected 0 1", dresp_data, timeout_err);
      end
      dreq_valid = 0;
      mem_lat = 0; mem_rdata = 64'h1234;
      step(); step(); step();
      dreq_valid = 1; dreq_addr = 64'h300;
      step();
      wait_ok(n, gi, gd);
      dreq_valid = 0;
      step();
      tests_run++;
      if (timeout_err !== 1'b1 || dresp_data !== 64'h1234) begin
         tests_failed++; $display("FAIL timeout_sticky: got err=%b d=%h expected 1 1234", timeout_err, dresp_data);
      end
   endtask

   // Runs right after test_timeout so timeout_err starts at 1.
   task automatic test_reset_mid_req();
      mem_lat = 5;
      dreq_valid = 1; dreq_addr = 64'h400;
      step();
      step();
      tests_run++;
      if (mreq_valid !== 1'b1) begin
         tests_failed++; $display("FAIL midreq_setup: got mreq_valid %b expected 1", mreq_valid);
      end
      reset = 1'b0;
      step();
      tests_run++;
      if ({mreq_valid, iresp_data_ok, dresp_data_ok, timeout_err} !== 4'b0000 || dresp_data !== 64'h0) begin
         tests_failed++; $display("FAIL midreq_reset: got v%b ok%b%b err%b d%h expected all 0",
                                  mreq_valid, iresp_data_ok, dresp_data_ok, timeout_err, dresp_data);
      end
      reset = 1'b1;
      clear_inputs();
      for (int k = 0; k < 6; k++) begin
         step();
         tests_run++;
         if ({mreq_valid, iresp_data_ok, dresp_data_ok, timeout_err} !== 4'b0000) begin
            tests_failed++; $display("FAIL midreq_idle%0d: got v%b ok%b%b err%b expected 0000",
                                     k, mreq_valid, iresp_data_ok, dresp_data_ok, timeout_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_back_to_back();
      test_field_change();
      test_random();
      test_timeout();
      test_reset_mid_req();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
